// File: rtl/l1_ahb_mtx_arb_rr_pkg.sv
// Shared L1 AHB matrix definitions: AHB transfer/burst codes,
// the arbiter state encoding and a burst length helper.
package l1_ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int CW = 8;

    typedef enum logic [1:0] {
        ST_NOPORT,
        ST_GRANT,
        ST_BURST,
        ST_LOCKED
    } arb_state_e;

    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] n;
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   n = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   n = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
            HBURST_SINGLE, HBURST_INCR:   n = 5'd0;
            default:                      n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/l1_ahb_mtx_arb_rr_if.sv
// Arbiter bus bundle: requests and slave address-phase controls in,
// registered grant (addr_in_port, no_port) out.
interface l1_ahb_mtx_arb_rr_if #(
    parameter int NUM_PORTS = 3,
    parameter int PW        = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PW-1:0]        addr_in_port;
    logic                 no_port;

    modport master (
        output req_port, HREADYM, HSELM,
        output HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port
    );

    modport slave (
        input  req_port, HREADYM, HSELM,
        input  HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port
    );
endinterface

// File: rtl/l1_ahb_mtx_rr_pick.sv
// Rotating-priority picker: first set req bit after i_last_ptr wins.
// Ports: i_req, i_last_ptr in; o_winner, o_any_req out.
module l1_ahb_mtx_rr_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PW-1:0]        i_last_ptr,
    output logic [PW-1:0]        o_winner,
    output logic                 o_any_req
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_winner = i_last_ptr;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = PW'((int'(i_last_ptr) + k) % NUM_PORTS);
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
        o_any_req = |i_req;
    end

endmodule

// File: rtl/l1_ahb_mtx_arb_rr.sv
// Round-robin, burst/lock-aware output arbiter for one slave port.
// Ports: HCLK, HRESETn (async low), bus (slave modport of arbiter if).
module l1_ahb_mtx_arb_rr
    import l1_ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int QUANTUM   = 16,
    parameter int PW        = $clog2(NUM_PORTS)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    l1_ahb_mtx_arb_rr_if.slave bus
);

    localparam logic [CW-1:0] QMAX     = CW'(QUANTUM - 1);
    localparam logic [PW-1:0] LAST_RST = PW'(NUM_PORTS - 1);

    arb_state_e    r_state, w_state;
    logic [PW-1:0] r_port, w_port;
    logic [PW-1:0] r_last, w_last;
    logic [PW-1:0] w_winner;
    logic          r_noport, w_noport;
    logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic          w_any, w_arb;
    logic          w_incr, w_fixed, w_others, w_in_burst;
    logic          w_seq, w_busy, w_nseq;

    l1_ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .i_req      (bus.req_port),
        .i_last_ptr (r_last),
        .o_winner   (w_winner),
        .o_any_req  (w_any)
    );

    assign w_incr     = (bus.HBURSTM == HBURST_INCR);
    assign w_fixed    = (burst_beats(bus.HBURSTM) != 5'd0);
    assign w_seq      = (bus.HTRANSM == HTRANS_SEQ);
    assign w_busy     = (bus.HTRANSM == HTRANS_BUSY);
    assign w_nseq     = (bus.HTRANSM == HTRANS_NONSEQ);
    assign w_in_burst = (r_state == ST_BURST);
    // Requests from anyone other than the current owner.
    assign w_others   = |(bus.req_port & ~(NUM_PORTS'(1) << r_port));
    // INCR beat count saturates at the quantum limit.
    assign w_cnt_inc  = (r_cnt == QMAX) ? QMAX : r_cnt + 1'b1;

    always_comb begin
        w_state  = r_state;
        w_port   = r_port;
        w_last   = r_last;
        w_noport = r_noport;
        w_cnt    = r_cnt;
        w_arb    = 1'b0;
        if (bus.HMASTLOCKM) begin
            w_state = ST_LOCKED;
            w_cnt   = '0;
        end else if (w_in_burst && w_busy &&
                     (w_incr || r_cnt != '0)) begin
            w_cnt = r_cnt;
        end else if (w_in_burst && w_seq && w_fixed &&
                     r_cnt != '0) begin
            w_cnt = r_cnt - 1'b1;
        end else if (w_in_burst && w_seq && w_incr &&
                     !(w_cnt_inc == QMAX && w_others)) begin
            w_cnt = w_cnt_inc;
        end else if (w_nseq && w_fixed) begin
            w_state = ST_BURST;
            w_cnt   = CW'(burst_beats(bus.HBURSTM) - 5'd1);
        end else if (w_nseq && w_incr) begin
            w_state = ST_BURST;
            w_cnt   = '0;
        end else begin
            w_arb = 1'b1;
        end
        if (w_arb) begin
            w_cnt = '0;
            unique case (1'b1)
                w_any: begin
                    w_port   = w_winner;
                    w_last   = w_winner;
                    w_noport = 1'b0;
                    w_state  = ST_GRANT;
                end
                (!w_any && bus.HSELM): begin
                    w_state = r_noport ? ST_NOPORT : ST_GRANT;
                end
                (!w_any && !bus.HSELM): begin
                    w_noport = 1'b1;
                    w_state  = ST_NOPORT;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_NOPORT;
            r_port   <= '0;
            r_last   <= LAST_RST;
            r_noport <= 1'b1;
            r_cnt    <= '0;
        end else if (bus.HREADYM) begin
            r_state  <= w_state;
            r_port   <= w_port;
            r_last   <= w_last;
            r_noport <= w_noport;
            r_cnt    <= w_cnt;
        end
    end

    assign bus.addr_in_port = r_port;
    assign bus.no_port      = r_noport;

endmodule

// File: tb/tb_l1_ahb_mtx_arb_rr.sv
// Directed-vector bench for the round-robin output arbiter
// (3 ports, quantum 4).
module tb_l1_ahb_mtx_arb_rr;
    import l1_ahb_mtx_pkg::*;

    typedef struct {
        bit         rst;
        logic [2:0] req;
        bit         rdy;
        bit         sel;
        logic [1:0] trans;
        logic [2:0] burst;
        bit         lock;
        logic [1:0] ep;
        bit         en;
    } vec_t;

    logic HCLK;
    logic HRESETn;
    int   n_tests;
    int   n_fail;
    vec_t tbl[$];

    l1_ahb_mtx_arb_rr_if #(.NUM_PORTS(3)) bus_if();

    l1_ahb_mtx_arb_rr #(
        .NUM_PORTS (3),
        .QUANTUM   (4)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_if)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic vec_t v(bit r, logic [2:0] q, bit rd,
                               bit s, logic [1:0] t,
                               logic [2:0] b, bit l,
                               logic [1:0] ep, bit en);
        vec_t x;
        x.rst = r; x.req = q; x.rdy = rd; x.sel = s;
        x.trans = t; x.burst = b; x.lock = l;
        x.ep = ep; x.en = en;
        return x;
    endfunction

    task automatic check(input string nm, input logic [1:0] ep,
                         input logic en);
        n_tests++;
        if (bus_if.addr_in_port !== ep || bus_if.no_port !== en) begin
            n_fail++;
            $display("FAIL %s: got port=%0d no_port=%0b, want port=%0d no_port=%0b",
                     nm, bus_if.addr_in_port, bus_if.no_port, ep, en);
        end
    endtask

    task automatic apply(input vec_t x, input string nm);
        @(negedge HCLK);
        HRESETn            = !x.rst;
        bus_if.req_port    = x.req;
        bus_if.HREADYM     = x.rdy;
        bus_if.HSELM       = x.sel;
        bus_if.HTRANSM     = x.trans;
        bus_if.HBURSTM     = x.burst;
        bus_if.HMASTLOCKM  = x.lock;
        @(posedge HCLK);
        #1;
        check(nm, x.ep, x.en);
    endtask

    localparam logic [1:0] I = HTRANS_IDLE;
    localparam logic [1:0] B = HTRANS_BUSY;
    localparam logic [1:0] N = HTRANS_NONSEQ;
    localparam logic [1:0] S = HTRANS_SEQ;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        HRESETn = 1'b0;
        bus_if.req_port   = '0;
        bus_if.HREADYM    = 1'b1;
        bus_if.HSELM      = 1'b0;
        bus_if.HTRANSM    = I;
        bus_if.HBURSTM    = HBURST_SINGLE;
        bus_if.HMASTLOCKM = 1'b0;

        // reset, round robin 0,1,2,0
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 3'b111, 1, 1, N, HBURST_SINGLE, 0,
                            2'((i) % 3), 0));
        // idle / HSELM hold / no port
        tbl.push_back(v(0, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b010, 1, 1, I, HBURST_SINGLE, 0, 1, 0));
        tbl.push_back(v(0, 3'b000, 1, 1, I, HBURST_SINGLE, 0, 1, 0));
        tbl.push_back(v(0, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 1, 1));
        tbl.push_back(v(0, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 1, 1));
        // INCR8 by port 1 with BUSY and stalls
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b010, 1, 1, I, HBURST_SINGLE, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, N, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, B, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 0, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 0, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 1, S, HBURST_INCR8, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 0, 0, I, HBURST_SINGLE, 0, 1, 0));
        tbl.push_back(v(0, 3'b011, 1, 0, I, HBURST_SINGLE, 0, 0, 0));
        // locked sequence by port 0
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b001, 1, 1, I, HBURST_SINGLE, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 3'b110, 1, 1, N, HBURST_SINGLE, 1, 0, 0));
        tbl.push_back(v(0, 3'b110, 1, 1, I, HBURST_SINGLE, 0, 1, 0));
        // WRAP4 cut short by IDLE
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b001, 1, 1, I, HBURST_SINGLE, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, N, HBURST_WRAP4, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, S, HBURST_WRAP4, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, S, HBURST_WRAP4, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, I, HBURST_SINGLE, 0, 1, 0));
        // INCR quantum with a competitor
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b100, 1, 1, I, HBURST_SINGLE, 0, 2, 0));
        tbl.push_back(v(0, 3'b001, 1, 1, N, HBURST_INCR, 0, 2, 0));
        tbl.push_back(v(0, 3'b001, 1, 1, S, HBURST_INCR, 0, 2, 0));
        tbl.push_back(v(0, 3'b001, 1, 1, S, HBURST_INCR, 0, 2, 0));
        tbl.push_back(v(0, 3'b001, 1, 1, S, HBURST_INCR, 0, 0, 0));
        // INCR alone: saturates, then yields to a late requester
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b100, 1, 1, I, HBURST_SINGLE, 0, 2, 0));
        tbl.push_back(v(0, 3'b100, 1, 1, N, HBURST_INCR, 0, 2, 0));
        for (int i = 0; i < 11; i++)
            tbl.push_back(v(0, 3'b100, 1, 1, S, HBURST_INCR, 0, 2, 0));
        tbl.push_back(v(0, 3'b101, 1, 1, S, HBURST_INCR, 0, 0, 0));
        // lock raised mid-burst clears the beat counter
        tbl.push_back(v(1, 3'b000, 1, 0, I, HBURST_SINGLE, 0, 0, 1));
        tbl.push_back(v(0, 3'b001, 1, 1, I, HBURST_SINGLE, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, N, HBURST_INCR8, 0, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, S, HBURST_INCR8, 1, 0, 0));
        tbl.push_back(v(0, 3'b010, 1, 1, S, HBURST_INCR8, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset in the middle of an INCR16
        apply(v(0, 3'b010, 1, 1, I, HBURST_SINGLE, 0, 1, 0), "i16_own");
        apply(v(0, 3'b011, 1, 1, N, HBURST_INCR16, 0, 1, 0), "i16_nseq");
        apply(v(0, 3'b011, 1, 1, S, HBURST_INCR16, 0, 1, 0), "i16_seq1");
        apply(v(0, 3'b011, 1, 1, S, HBURST_INCR16, 0, 1, 0), "i16_seq2");
        #1;
        HRESETn = 1'b0;
        #1;
        check("async_rst", 2'd0, 1'b0 + 1'b1);
        apply(v(1, 3'b011, 1, 1, S, HBURST_INCR16, 0, 0, 1), "rst_hold");
        apply(v(0, 3'b111, 1, 1, N, HBURST_SINGLE, 0, 0, 0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
